packet_receiver: RTL and testbench

//  Ingress stage of the router port. It parses the byte stream framed by packet_valid:
//  SRC_ID, DST_ID, SIZE, SIZE data bytes, CRC. Each byte is written into the current slot
//  of the packet buffer at its fixed field offset.
//  A slot is committed with a winc pulse only when the checksum matches. packet_sender drains the slots.

---
 rtl/packet_receiver_pkg.sv | 21 ++
 rtl/packet_receiver_if.sv | 28 ++
 rtl/packet_receiver_pkt_chk.sv | 28 ++
 rtl/packet_receiver.sv | 170 +++++++++++++++++
 tb/tb_packet_receiver.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_receiver_pkg.sv
// Shared definitions for the router port packet path: field offsets, size field width
// and the parser state codes (also used by packet_sender).
package packet_receiver_pkg;

   localparam int OFF_SRC_ID = 0;
   localparam int OFF_DST_ID = 1;
   localparam int OFF_SIZE   = 2;
   localparam int OFF_DATA   = 3;

   localparam int SIZE_BITS  = 3;

   typedef enum logic [2:0] {
      IDLE,
      DST,
      SIZE,
      DATA,
      CRC,
      DISCARD
   } rx_state_t;

endpackage

// File: rtl/packet_receiver_if.sv
// Ingress stream plus packet-buffer write port of the receiver.
// master = stream source / buffer side, slave = packet_receiver.
interface packet_receiver_if #(
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4
);

   logic                 packet_valid;
   logic [UWIDTH-1:0]    packet_in;
   logic                 wfull;
   logic                 wen;
   logic [PTR_IN_SZ-1:0] waddr;
   logic [UWIDTH-1:0]    wdata;
   logic                 winc;
   logic                 crc_err;
   logic                 drop;

   modport master (
      output packet_valid, packet_in, wfull,
      input  wen, waddr, wdata, winc, crc_err, drop
   );

   modport slave (
      input  packet_valid, packet_in, wfull,
      output wen, waddr, wdata, winc, crc_err, drop
   );

endinterface

// File: rtl/packet_receiver_pkt_chk.sv
// pkt_chk: running XOR checksum. i_clr restarts the sum; with i_en in the same cycle
// the sum restarts at i_data instead of zero.
module pkt_chk #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_acc
);

   logic [WIDTH-1:0] r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= i_en ? i_data : '0;
      end else if (i_en) begin
         r_acc <= r_acc ^ i_data;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: parses SRC/DST/SIZE/DATA/CRC frames into the current buffer slot and
// commits the slot only on a checksum match. Optional DST filtering: PKT_RX_DST_FILTER_EN.
module packet_receiver
   import packet_receiver_pkg::*;
#(
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4,
   parameter int LOCAL_ID  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   packet_receiver_if.slave   bus
);

   localparam logic [UWIDTH-1:0] LOCAL_ID_B = UWIDTH'(LOCAL_ID);

`ifdef PKT_RX_DST_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   rx_state_t             r_state;
   logic [SIZE_BITS-1:0]  r_cnt;
   logic [PTR_IN_SZ-1:0]  r_off;
   logic                  r_wen;
   logic [PTR_IN_SZ-1:0]  r_waddr;
   logic [UWIDTH-1:0]     r_wdata;
   logic                  r_winc;
   logic                  r_crcErr;
   logic                  r_drop;

   logic [SIZE_BITS-1:0]  w_size;
   logic                  w_dstReject;
   logic                  w_chkClr;
   logic                  w_chkEn;
   logic [UWIDTH-1:0]     w_acc;

   assign w_size      = bus.packet_in[SIZE_BITS-1:0];
   assign w_dstReject = FILTER_EN && (bus.packet_in != LOCAL_ID_B);

   // The checksum covers every byte that is written before the CRC byte itself.
   assign w_chkClr = (r_state == IDLE);
   assign w_chkEn  = bus.packet_valid &&
                     (((r_state == IDLE) && !bus.wfull) ||
                      ((r_state == DST)  && !w_dstReject) ||
                      ((r_state == SIZE) && (w_size != '0)) ||
                      (r_state == DATA));

   pkt_chk #(
      .WIDTH (UWIDTH)
   ) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_chkClr),
      .i_en   (w_chkEn),
      .i_data (bus.packet_in),
      .o_acc  (w_acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_off    <= '0;
         r_wen    <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_winc   <= 1'b0;
         r_crcErr <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_wen    <= 1'b0;
         r_winc   <= 1'b0;
         r_crcErr <= 1'b0;
         r_drop   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.packet_valid) begin
                  if (bus.wfull) begin
                     r_drop  <= 1'b1;
                     r_state <= DISCARD;
                  end else begin
                     r_wen   <= 1'b1;
                     r_waddr <= PTR_IN_SZ'(OFF_SRC_ID);
                     r_wdata <= bus.packet_in;
                     r_state <= DST;
                  end
               end
            end
            DST: begin
               if (!bus.packet_valid) begin
                  r_drop  <= 1'b1;
                  r_state <= IDLE;
               end else if (w_dstReject) begin
                  r_drop  <= 1'b1;
                  r_state <= DISCARD;
               end else begin
                  r_wen   <= 1'b1;
                  r_waddr <= PTR_IN_SZ'(OFF_DST_ID);
                  r_wdata <= bus.packet_in;
                  r_state <= SIZE;
               end
            end
            SIZE: begin
               if (!bus.packet_valid) begin
                  r_drop  <= 1'b1;
                  r_state <= IDLE;
               end else if (w_size == '0) begin
                  r_drop  <= 1'b1;
                  r_state <= DISCARD;
               end else begin
                  r_wen   <= 1'b1;
                  r_waddr <= PTR_IN_SZ'(OFF_SIZE);
                  r_wdata <= bus.packet_in;
                  r_cnt   <= w_size - SIZE_BITS'(1);
                  r_off   <= PTR_IN_SZ'(OFF_DATA);
                  r_state <= DATA;
               end
            end
            // r_off walks through the data bytes and lands on the CRC offset.
            DATA: begin
               if (!bus.packet_valid) begin
                  r_drop  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_wen   <= 1'b1;
                  r_waddr <= r_off;
                  r_wdata <= bus.packet_in;
                  r_off   <= r_off + PTR_IN_SZ'(1);
                  if (r_cnt == '0) begin
                     r_state <= CRC;
                  end else begin
                     r_cnt <= r_cnt - SIZE_BITS'(1);
                  end
               end
            end
            CRC: begin
               if (!bus.packet_valid) begin
                  r_drop  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_wen    <= 1'b1;
                  r_waddr  <= r_off;
                  r_wdata  <= bus.packet_in;
                  r_winc   <= (bus.packet_in == w_acc);
                  r_crcErr <= (bus.packet_in != w_acc);
                  r_state  <= IDLE;
               end
            end
            DISCARD: begin
               if (!bus.packet_valid) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.wen     = r_wen;
   assign bus.waddr   = r_waddr;
   assign bus.wdata   = r_wdata;
   assign bus.winc    = r_winc;
   assign bus.crc_err = r_crcErr;
   assign bus.drop    = r_drop;

endmodule

// File: tb/tb_packet_receiver.sv
// Self-checking bench for packet_receiver: directed frames plus randomized frames scored
// against a frame-level outcome model. Set PKT_RX_DST_FILTER_EN to match the RTL build.
module tb_packet_receiver;

   localparam int UWIDTH    = 8;
   localparam int PTR_IN_SZ = 4;
   localparam int LOCAL_ID  = 3;

`ifdef PKT_RX_DST_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   typedef logic [7:0] pkt_t [0:10];
   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   packet_receiver_if #(.UWIDTH(UWIDTH), .PTR_IN_SZ(PTR_IN_SZ)) bus ();

   packet_receiver #(
      .UWIDTH    (UWIDTH),
      .PTR_IN_SZ (PTR_IN_SZ),
      .LOCAL_ID  (LOCAL_ID)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cycle  = 0;
   bit monEn  = 1'b0;

   wr_t expWr[$];
   wr_t obsWr[$];
   int  expWincAddr[$];
   int  obsWincAddr[$];
   int  obsWincWen[$];
   int  wincCycles[$];
   int  expCrcErr = 0;
   int  expDrop   = 0;
   int  obsCrcErr = 0;
   int  obsDrop   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   always @(posedge clk) cycle++;

   // Record every observable event away from the active edge.
   always @(negedge clk) begin
      if (monEn) begin
         if (bus.wen) expWr.size(); 
         if (bus.wen) obsWr.push_back('{addr: int'(bus.waddr), data: int'(bus.wdata)});
         if (bus.winc) begin
            obsWincAddr.push_back(int'(bus.waddr));
            obsWincWen.push_back(int'(bus.wen));
            wincCycles.push_back(cycle);
         end
         if (bus.crc_err) obsCrcErr++;
         if (bus.drop) obsDrop++;
      end
   end

   function automatic pkt_t withCrc(input logic [87:0] w, input int n);
      pkt_t p;
      logic [7:0] x;
      for (int i = 0; i < 11; i++) p[i] = 8'h00;
      for (int i = 0; i < n; i++) p[i] = w[8*(n-1-i) +: 8];
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x = x ^ p[i];
      p[n-1] = x;
      return p;
   endfunction

   // Frame-level outcome: which bytes land in the slot and how the frame ends.
   // Returns 1 when the frame ends on its CRC byte (a zero gap may follow).
   function automatic bit modelPacket(input pkt_t p, input int n, input bit full);
      int sz;
      int total;
      int nWr;
      logic [7:0] x;
      if (n == 0) return 1'b0;
      if (full) begin
         expDrop++;
         return 1'b0;
      end
      if (n == 1 || (FILTER && p[1] != 8'(LOCAL_ID))) begin
         expWr.push_back('{addr: 0, data: int'(p[0])});
         expDrop++;
         return 1'b0;
      end
      sz = int'(p[2] % 8);
      if (n == 2 || sz == 0) begin
         expWr.push_back('{addr: 0, data: int'(p[0])});
         expWr.push_back('{addr: 1, data: int'(p[1])});
         expDrop++;
         return 1'b0;
      end
      total = 4 + sz;
      nWr = (n < total) ? n : total;
      for (int i = 0; i < nWr; i++) expWr.push_back('{addr: i, data: int'(p[i])});
      if (n < total) begin
         expDrop++;
         return 1'b0;
      end
      x = 8'h00;
      for (int i = 0; i < total - 1; i++) x = x ^ p[i];
      if (p[total-1] == x) expWincAddr.push_back(total - 1);
      else expCrcErr++;
      return 1'b1;
   endfunction

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.packet_valid = 1'b0;
         bus.packet_in    = 8'($urandom);
         bus.wfull        = 1'($urandom);
      end
   endtask

   task automatic applyStimulus(input pkt_t p, input int n, input bit full, input int gap);
      bit clean;
      clean = modelPacket(p, n, full);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.packet_valid = 1'b1;
         bus.packet_in    = p[i];
         bus.wfull        = (i == 0) ? full : 1'($urandom);
      end
      idleCycles((!clean && gap == 0) ? 1 : gap);
   endtask

   initial begin
      pkt_t p;
      int   k;
      int   sz;
      int   kind;
      int   n;
      bit   full;
      int   nCmp;

      bus.packet_valid = 1'b0;
      bus.packet_in    = 8'h00;
      bus.wfull        = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset_wen",     bus.wen,     1'b0);
      checkOutput("reset_waddr",   bus.waddr,   4'h0);
      checkOutput("reset_wdata",   bus.wdata,   8'h00);
      checkOutput("reset_winc",    bus.winc,    1'b0);
      checkOutput("reset_crc_err", bus.crc_err, 1'b0);
      checkOutput("reset_drop",    bus.drop,    1'b0);
      rst_n = 1'b1;

      // Partial frame interrupted by reset: must leave no trace.
      p = withCrc(88'h21_03_05_10_11_12_13_14_00, 9);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.packet_valid = 1'b1;
         bus.packet_in    = p[i];
      end
      @(negedge clk);
      bus.packet_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wen",   bus.wen,   1'b0);
      checkOutput("midrst_waddr", bus.waddr, 4'h0);
      checkOutput("midrst_winc",  bus.winc,  1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      monEn = 1'b1;

      applyStimulus(withCrc(88'h01_02_03_AA_BB_CC_00, 7), 7, 1'b0, 2);
      p = withCrc(88'h01_02_03_AA_BB_CC_00, 7);
      p[6] = p[6] ^ 8'h01;
      applyStimulus(p, 7, 1'b0, 2);
      applyStimulus(withCrc(88'h05_03_02_11_22_00, 6), 6, 1'b1, 2);
      applyStimulus(withCrc(88'h07_03_05_40_41_42_43_44_00, 9), 4, 1'b0, 1);
      applyStimulus(withCrc(88'h08_03_01_5A_00, 5), 5, 1'b0, 2);

      k = wincCycles.size();
      applyStimulus(withCrc(88'h09_03_01_33_00, 5), 5, 1'b0, 0);
      applyStimulus(withCrc(88'h0A_03_01_44_00, 5), 5, 1'b0, 3);
      checkOutput("b2b_winc_count", wincCycles.size() - k, 2);
      if (wincCycles.size() >= k + 2)
         checkOutput("b2b_winc_spacing", wincCycles[k+1] - wincCycles[k], 5);

      applyStimulus(withCrc(88'h0B_04_01_55_00, 5), 5, 1'b0, 2);
      applyStimulus(withCrc(88'h0C_03_01_66_00, 5), 5, 1'b0, 2);

      for (int pk = 0; pk < 40; pk++) begin
         for (int i = 0; i < 11; i++) p[i] = 8'($urandom);
         kind = $urandom_range(0, 9);
         sz   = (kind == 2) ? 0 : $urandom_range(1, 7);
         p[1] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(LOCAL_ID);
         p[2] = {p[2][7:3], 3'(sz)};
         n    = (sz == 0) ? 4 : 4 + sz;
         p[n-1] = 8'h00;
         for (int i = 0; i < n - 1; i++) p[n-1] = p[n-1] ^ p[i];
         if (kind == 1) p[n-1] = p[n-1] ^ 8'($urandom_range(1, 255));
         if (kind == 3) n = $urandom_range(1, n - 1);
         full = (kind == 4);
         applyStimulus(p, n, full, $urandom_range(0, 2));
      end
      idleCycles(4);

      checkOutput("write_count", obsWr.size(), expWr.size());
      nCmp = (obsWr.size() < expWr.size()) ? obsWr.size() : expWr.size();
      for (int i = 0; i < nCmp; i++) begin
         checkOutput($sformatf("write%0d_addr", i), obsWr[i].addr, expWr[i].addr);
         checkOutput($sformatf("write%0d_data", i), obsWr[i].data, expWr[i].data);
      end
      checkOutput("winc_count", obsWincAddr.size(), expWincAddr.size());
      nCmp = (obsWincAddr.size() < expWincAddr.size()) ? obsWincAddr.size() : expWincAddr.size();
      for (int i = 0; i < nCmp; i++) begin
         checkOutput($sformatf("winc%0d_addr", i), obsWincAddr[i], expWincAddr[i]);
         checkOutput($sformatf("winc%0d_with_wen", i), obsWincWen[i], 1);
      end
      checkOutput("crc_err_count", obsCrcErr, expCrcErr);
      checkOutput("drop_count", obsDrop, expDrop);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
